// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a fixed integer baud divisor, feeding a small show-ahead FIFO.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ = 48_000_000,
  parameter int unsigned BAUD   = 115_200,
  parameter int unsigned DEPTH  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV) + 1;
  localparam int unsigned AW   = $clog2(DEPTH);

  if (DIV < 4) begin : g_div_chk
    $error("uart_rx_fifo: baud divisor must be at least 4");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  // Two-flop synchronizer plus one delayed copy for start-edge detection
  logic s1_q, rs_q, rp_q;
  logic fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b1;
      rs_q <= 1'b1;
      rp_q <= 1'b1;
    end else begin
      s1_q <= rx;
      rs_q <= s1_q;
      rp_q <= rs_q;
    end
  end

  assign fall = rp_q & ~rs_q;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bi_q, bi_d;
  logic [7:0]    sh_q, sh_d;
  logic          push, fe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bi_d    = bi_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          cnt_d   = CW'(HALF - 1);
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          // A start bit that is high again at mid-bit was a glitch
          if (!rs_q) begin
            state_d = StData;
            cnt_d   = CW'(DIV - 1);
            bi_d    = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          sh_d  = {rs_q, sh_q[7:1]};
          cnt_d = CW'(DIV - 1);
          if (bi_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bi_d = bi_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          push    = rs_q;
          fe_d    = ~rs_q;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bi_q    <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bi_q    <= bi_d;
      sh_q    <= sh_d;
    end
  end

  // FIFO with one extra pointer bit to tell full from empty
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, pop, do_push, ov_d;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = ~empty & ready;
  assign do_push = push & (~full | pop);
  assign ov_d    = push & full & ~pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      frame_err <= fe_d;
      overrun   <= ov_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= sh_q;
  end

  assign valid = ~empty;
  assign data  = valid ? mem_q[rd_q[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a frame-level queue model compared every cycle,
// plus literal expectations at hand-computed cycles.
module tb_uart_rx_fifo;

  localparam int unsigned DIV    = 48;
  localparam int unsigned HALF   = 24;
  localparam int unsigned DEPTH  = 4;
  // From the cycle rx first goes low to the stop-sample cycle: 2 sync + HALF + 9 bit times
  localparam int          TS_OFS = 2 + HALF + 9 * DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .CLK_HZ(48_000_000),
    .BAUD  (1_000_000),
    .DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Frames announced by the stimulus: stop-sample cycle, stop bit good, byte
  int         ev_ts   [64];
  bit         ev_good [64];
  logic [7:0] ev_byte [64];
  int         nfr = 0;
  int         rdi = 0;

  // One literal expectation at a time, set up by the stimulus
  int         lit_cyc = -1;
  logic       lit_v, lit_fe, lit_ov;
  logic [7:0] lit_d;
  int         lit_n;

  logic [7:0] mq[$];
  bit         p_rst  = 1'b1;
  bit         p_pop  = 1'b0;
  bit         p_push = 1'b0;
  bit         p_fe   = 1'b0;
  logic [7:0] p_byte = 8'h00;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    bit         e_fe, e_ov, e_v;
    logic [7:0] e_d;
    if (cyc > 0) begin
      e_fe = 1'b0;
      e_ov = 1'b0;
      if (p_rst) begin
        mq.delete();
        rdi = nfr;
      end else begin
        if (p_pop) void'(mq.pop_front());
        if (p_push) begin
          if (mq.size() == DEPTH) e_ov = 1'b1;
          else mq.push_back(p_byte);
        end
        e_fe = p_fe;
      end
      e_v = (mq.size() > 0);
      e_d = e_v ? mq[0] : 8'h00;
      chk("valid", {7'd0, valid}, {7'd0, e_v});
      chk("frame_err", {7'd0, frame_err}, {7'd0, e_fe});
      chk("overrun", {7'd0, overrun}, {7'd0, e_ov});
      if (e_v) chk("data", data, e_d);
      if (cyc == lit_cyc) begin
        chk("lit_valid", {7'd0, valid}, {7'd0, lit_v});
        chk("lit_data", data, lit_d);
        chk("lit_frame_err", {7'd0, frame_err}, {7'd0, lit_fe});
        chk("lit_overrun", {7'd0, overrun}, {7'd0, lit_ov});
        chk("lit_model_depth", 8'(mq.size()), 8'(lit_n));
      end
      // Record what happens during this cycle for the next update
      p_rst  = reset;
      p_pop  = e_v && ready && !reset;
      p_push = 1'b0;
      p_fe   = 1'b0;
      while (rdi < nfr && ev_ts[rdi] < cyc) rdi++;
      if (rdi < nfr && ev_ts[rdi] == cyc) begin
        p_push = ev_good[rdi];
        p_fe   = !ev_good[rdi];
        p_byte = ev_byte[rdi];
        rdi++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lit(input int c, input logic v, input logic [7:0] d, input logic fe,
                         input logic ov, input int n);
    lit_v   = v;
    lit_d   = d;
    lit_fe  = fe;
    lit_ov  = ov;
    lit_n   = n;
    lit_cyc = c;
  endtask

  // Drives one frame; abort_bit >= 0 releases the line high at that data bit and returns
  task automatic send_frame(input logic [7:0] b, input bit stop, input int abort_bit,
                            input bit pulse_rdy);
    int m;
    m = cyc;
    ev_ts[nfr]   = m + TS_OFS;
    ev_good[nfr] = stop;
    ev_byte[nfr] = b;
    nfr++;
    rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        rx = 1'b1;
        return;
      end
      rx = b[i];
      repeat (DIV) tick();
    end
    rx = stop;
    for (int k = 0; k < DIV; k++) begin
      if (pulse_rdy) ready = (cyc == m + TS_OFS);
      tick();
    end
    if (pulse_rdy) ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();

    // Single byte, consumer always ready
    ready = 1'b1;
    set_lit(cyc + TS_OFS + 1, 1'b1, 8'hA5, 1'b0, 1'b0, 1);
    send_frame(8'hA5, 1'b1, -1, 1'b0);
    repeat (10) tick();

    // Five frames into a 4-deep FIFO with no consumer, then drain
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) set_lit(cyc + TS_OFS + 1, 1'b1, 8'h01, 1'b0, 1'b1, 4);
      send_frame(8'(i), 1'b1, -1, 1'b0);
    end
    repeat (5) tick();
    ready = 1'b1;
    repeat (10) tick();

    // Framing error followed by a long break, then a good frame
    set_lit(cyc + TS_OFS + 1, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    send_frame(8'h3C, 1'b0, -1, 1'b0);
    rx = 1'b0;
    repeat (20 * DIV) tick();
    rx = 1'b1;
    repeat (100) tick();
    set_lit(cyc + TS_OFS + 1, 1'b1, 8'h7E, 1'b0, 1'b0, 1);
    send_frame(8'h7E, 1'b1, -1, 1'b0);
    repeat (10) tick();

    // Short low glitch on an idle line
    set_lit(cyc + 2 + HALF + 1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    rx = 1'b0;
    repeat (10) tick();
    rx = 1'b1;
    repeat (100) tick();

    // Reset mid-frame with two bytes queued
    ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, 1'b0);
    send_frame(8'h22, 1'b1, -1, 1'b0);
    send_frame(8'h55, 1'b1, 4, 1'b0);
    set_lit(cyc + 1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    ready = 1'b1;
    set_lit(cyc + TS_OFS + 1, 1'b1, 8'hC3, 1'b0, 1'b0, 1);
    send_frame(8'hC3, 1'b1, -1, 1'b0);
    repeat (10) tick();

    // Full FIFO, pop coinciding with the stop sample of a fifth frame
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'hA0 + 8'(i), 1'b1, -1, 1'b0);
    set_lit(cyc + TS_OFS + 1, 1'b1, 8'hA2, 1'b0, 1'b0, 4);
    send_frame(8'hA5, 1'b1, -1, 1'b1);
    repeat (5) tick();
    ready = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front-end sitting between the board's rx pad and the core's byte-level receive port. It synchronizes the asynchronous rx line and recovers 8N1 frames using a fixed integer baud divisor. It buffers received bytes in a small show-ahead FIFO drained through a valid/ready handshake, and reports framing errors and overruns as single-cycle pulses.

## Interface
- CLK_HZ, 48_000_000 — frequency of `clock` in Hz
- BAUD, 115_200 — line rate in bit/s; DIV = (CLK_HZ + BAUD/2) / BAUD, HALF = DIV/2 (floor); DIV < 4 is an elaboration error
- DEPTH, 4 — FIFO entries; power of two, ≥ 2; pointers are log2(DEPTH)+1 bits wide
- clock  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input, idle high
- data  out  8  FIFO head byte, valid only while `valid` = 1
- valid  out  1  FIFO non-empty
- ready  in  1  consumer accepts head; pop when valid & ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: good byte dropped, FIFO full

## Operation
- Synchronizer: two flops, both reset to 1; `rs` = second stage; `rp` = previous `rs` (reset 1). Falling edge = rp & !rs.
- FSM states: IDLE, START, DATA, STOP. Down-counter `cnt` (width ⌈log2 DIV⌉+1), bit index `bi` (3 bits), shift register `sh` (8 bits).
- IDLE: on falling edge → START, cnt = HALF−1.
- START: cnt counts to 0; at 0 sample `rs`: low → DATA, cnt = DIV−1, bi = 0; high (glitch) → IDLE, nothing pushed, no error.
- DATA: at cnt = 0 shift `rs` into sh MSB (LSB-first on line), reload cnt = DIV−1; after bi = 7 → STOP, else bi+1.
- STOP: at cnt = 0 sample `rs`: high → push sh, → IDLE; low → frame_err pulse, byte discarded, → IDLE. A held-low line (break) never triggers a new frame until it has returned high, because of edge detection.
- Push with FIFO full and no pop in the same cycle: byte dropped, overrun pulse, FIFO contents unchanged.
- Full FIFO with simultaneous pop and push: both occur, no overrun.
- Empty FIFO with push: byte is visible on `data`/`valid` the next cycle. There is no bypass.
- `data` holds steady while valid & !ready.
- Reset mid-frame: FSM → IDLE, FIFO emptied, partial byte discarded, no pulses.

## Timing
- Reset values: data = 0, valid = 0, frame_err = 0, overrun = 0; FSM IDLE, pointers 0.
- Pin to `rs` latency: 2 cycles. Let t0 be the cycle in which the falling edge is detected.
- Start check at t0 + HALF. Data bit i (0..7) sampled at t0 + HALF + (i+1)·DIV. Stop bit sampled at t0 + HALF + 9·DIV.
- At the stop-sample cycle + 1: push visible (valid = 1), or frame_err/overrun asserted for exactly 1 cycle.
- Pop: valid & ready at cycle t advances the head at t+1. Back-to-back pops at 1 byte/cycle are allowed.
- Throughput: one frame per 10·DIV cycles. The FSM returns to IDLE at the stop-sample cycle, so the next start edge is detected immediately.

## Test plan
- CLK_HZ = 48e6, BAUD = 1e6 (DIV = 48, HALF = 24), ready = 1, send 0xA5 → valid = 1 with data = 0xA5 for one cycle at t0 + 457; frame_err = overrun = 0.
- Same config, ready = 0, send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back → valid stays high with data = 0x01; one overrun pulse after frame 5. Then ready = 1 → drains 0x01..0x04 on 4 consecutive cycles, then valid = 0.
- Frame 0x3C with stop bit forced low → frame_err pulse at t0 + 457, valid stays 0. Hold rx low 20 bit-times, then release → no further output. The next good frame 0x7E is received correctly.
- 10-cycle low glitch on idle rx → FSM returns to IDLE at t0 + 24; no output, no pulses.
- Assert reset at bit 4 of frame 0x55, with 2 bytes already queued → next cycle valid = 0, all outputs 0. The following 0xC3 frame is received intact.
- FIFO full with ready = 1 asserted in the same cycle as the stop sample → pop and push both happen, no overrun, and the new byte appears last in order.
